// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit (MDU) datapath.
// Holds the FSM state enum, operand width, iteration count and sign helpers.
package mdu_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Magnitude of a two's-complement word; -2^(W-1) maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                              input logic             use_sign);
    logic [WIDTH-1:0] r;
    if (use_sign && v[WIDTH-1]) begin
      r = ~v + WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign pre/post-processing shared by the sequential multiplier and divider:
// operand magnitudes, result sign, and conditional double-width negate.
module mdu_sign_fix
  import mdu_pkg::*;
(
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     a_mag,
  output logic [WIDTH-1:0]     b_mag,
  output logic                 neg_res,
  input  logic [2*WIDTH-1:0]   mag_in,
  input  logic                 neg_in,
  output logic [2*WIDTH-1:0]   res_out
);

  assign a_mag   = mag_of(a, is_signed);
  assign b_mag   = mag_of(b, is_signed);
  assign neg_res = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign res_out = neg_in ? neg2w(mag_in) : mag_in;

endmodule

// File: rtl/mul32_seq.sv
// 32x32 -> 64 shift-add multiplier, one partial product per cycle.
// Fixed 33-cycle latency from accepted start to the single-cycle done pulse.
module mul32_seq
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic                  neg_q, neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;

  logic [WIDTH-1:0]      a_mag_s, b_mag_s;
  logic                  neg_s;
  logic [2*WIDTH-1:0]    prod_s;
  logic [WIDTH-1:0]      addend_s;
  logic [WIDTH:0]        sum_s;

  mdu_sign_fix u_sign_fix (
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .a_mag     (a_mag_s),
    .b_mag     (b_mag_s),
    .neg_res   (neg_s),
    .mag_in    (acc_q),
    .neg_in    (neg_q),
    .res_out   (prod_s)
  );

  // State register; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one add/shift iteration per RUN cycle.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
    // Carry of the upper-half add lands in the MSB after the shift.
    sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag_s;
          mplier_d = b_mag_s;
          neg_d    = neg_s;
          cnt_d    = {CNT_W{1'b0}};
          acc_d    = {(2*WIDTH){1'b0}};
        end else begin
          cnt_d    = cnt_q;
        end
      end
      RUN: begin
        acc_d    = {sum_s, acc_q[WIDTH-1:1]};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output logic; hi/lo only change on leaving DONE.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_q == DONE);
    if (state_q == DONE) begin
      hi_d = prod_s[2*WIDTH-1:WIDTH];
      lo_d = prod_s[WIDTH-1:0];
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
